// File: rtl/uart_apb_sequencer.sv
// APB master that programs one apb_uart and then shuttles bytes between valid/ready streams and TBR/RBR.
// Optional feature: define APB_TIMEOUT_EN to abandon an ACCESS phase after TIMEOUT_CYCLES cycles without PREADY.
module uart_apb_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [1:0]  cfg_wls,
  input  logic        cfg_stb,
  input  logic        cfg_pen,
  input  logic        cfg_eps,
  input  logic        cfg_osm_sel,
  input  logic [15:0] cfg_divisor,
  input  logic [7:0]  cfg_ier,
  output logic        cfg_busy,
  output logic        cfg_done,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        tx_fifo_full,
  input  logic        rx_fifo_empty,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_SETUP, S_CFG_ACCESS, S_RUN,
    S_RD_SETUP, S_RD_ACCESS, S_WR_SETUP, S_WR_ACCESS
  } state_t;

  localparam logic [2:0] OFF_MDR = 3'd0;
  localparam logic [2:0] OFF_DLL = 3'd1;
  localparam logic [2:0] OFF_DLH = 3'd2;
  localparam logic [2:0] OFF_LCR = 3'd3;
  localparam logic [2:0] OFF_IER = 3'd4;
  localparam logic [2:0] OFF_TBR = 3'd6;
  localparam logic [2:0] OFF_RBR = 3'd7;

  state_t      r_state, w_next;
  logic [2:0]  r_idx;
  logic [1:0]  r_wls;
  logic        r_stb, r_pen, r_eps, r_osm;
  logic [15:0] r_div;
  logic [7:0]  r_ier;
  logic [7:0]  r_wbyte;
  logic        r_cfg_pend, r_done, r_err, r_rx_valid;
  logic [7:0]  r_rx_data;

  logic        w_in_cfg, w_access, w_cfg_take, w_enter_cfg, w_timeout;
  logic [2:0]  w_off;
  logic [7:0]  w_cfg_dat;
  logic        w_unused;

  assign w_in_cfg    = (r_state == S_CFG_SETUP) || (r_state == S_CFG_ACCESS);
  assign w_access    = (r_state == S_CFG_ACCESS) || (r_state == S_RD_ACCESS) ||
                       (r_state == S_WR_ACCESS);
  assign w_cfg_take  = cfg_start && !w_in_cfg;
  assign w_enter_cfg = ((r_state == S_IDLE) || (r_state == S_RUN)) && (w_next == S_CFG_SETUP);

`ifdef APB_TIMEOUT_EN
  logic [31:0] r_tcnt;

  assign w_timeout = w_access && !PREADY && (r_tcnt == TIMEOUT_CYCLES - 1);
  assign w_unused  = &{1'b0, PRDATA[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_tcnt <= '0;
    else if (w_access) r_tcnt <= r_tcnt + 32'd1;
    else               r_tcnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
  assign w_unused  = &{1'b0, PRDATA[31:8], TIMEOUT_CYCLES[0]};
`endif

  // Configuration write table: index selects register offset and data from the shadow copy.
  always_comb begin
    w_off     = OFF_LCR;
    w_cfg_dat = '0;
    case (r_idx)
      3'd0:    begin w_off = OFF_LCR; w_cfg_dat = {3'b000, r_eps, r_pen, r_stb, r_wls}; end
      3'd1:    begin w_off = OFF_MDR; w_cfg_dat = {7'b0, r_osm}; end
      3'd2:    begin w_off = OFF_DLH; w_cfg_dat = r_div[15:8]; end
      3'd3:    begin w_off = OFF_DLL; w_cfg_dat = r_div[7:0]; end
      3'd4:    begin w_off = OFF_IER; w_cfg_dat = r_ier; end
      default: begin w_off = OFF_LCR; w_cfg_dat = {3'b001, r_eps, r_pen, r_stb, r_wls}; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    tx_ready = 1'b0;
    cfg_busy = w_in_cfg;
    case (r_state)
      S_IDLE: begin
        if (cfg_start || r_cfg_pend) w_next = S_CFG_SETUP;
      end
      S_CFG_SETUP, S_CFG_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == S_CFG_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = BASE_ADDR + {29'b0, w_off};
        PWDATA  = {24'b0, w_cfg_dat};
        if (r_state == S_CFG_SETUP)  w_next = S_CFG_ACCESS;
        else if (PREADY)             w_next = (r_idx == 3'd5) ? S_RUN : S_CFG_SETUP;
      end
      S_RUN: begin
        if (cfg_start || r_cfg_pend)             w_next = S_CFG_SETUP;
        else if (!rx_fifo_empty && !r_rx_valid)  w_next = S_RD_SETUP;
        else if (tx_valid && !tx_fifo_full)      w_next = S_WR_SETUP;
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == S_RD_ACCESS);
        PADDR   = BASE_ADDR + {29'b0, OFF_RBR};
        if (r_state == S_RD_SETUP) w_next = S_RD_ACCESS;
        else if (PREADY)           w_next = S_RUN;
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == S_WR_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = BASE_ADDR + {29'b0, OFF_TBR};
        // SETUP presents the live stream byte; ACCESS replays the copy taken at the handshake.
        PWDATA  = {24'b0, (r_state == S_WR_SETUP) ? tx_data : r_wbyte};
        tx_ready = (r_state == S_WR_SETUP);
        if (r_state == S_WR_SETUP) w_next = S_WR_ACCESS;
        else if (PREADY)           w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_wls      <= '0;
      r_stb      <= 1'b0;
      r_pen      <= 1'b0;
      r_eps      <= 1'b0;
      r_osm      <= 1'b0;
      r_div      <= '0;
      r_ier      <= '0;
      r_wbyte    <= '0;
      r_cfg_pend <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      if (w_cfg_take) begin
        r_wls  <= cfg_wls;
        r_stb  <= cfg_stb;
        r_pen  <= cfg_pen;
        r_eps  <= cfg_eps;
        r_osm  <= cfg_osm_sel;
        r_div  <= cfg_divisor;
        r_ier  <= cfg_ier;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      // A start seen mid-transfer in RUN is remembered until the FSM can enter CFG.
      r_cfg_pend <= (r_cfg_pend || w_cfg_take) && !w_enter_cfg;

      if (w_enter_cfg)                               r_idx <= '0;
      else if (r_state == S_CFG_ACCESS && PREADY)    r_idx <= r_idx + 3'd1;

      if (r_state == S_CFG_ACCESS && PREADY && r_idx == 3'd5) r_done <= 1'b1;
      if (r_state == S_WR_SETUP) r_wbyte <= tx_data;

      if (r_state == S_RD_ACCESS && PREADY) begin
        r_rx_data  <= PRDATA[7:0];
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_access && PREADY && PSLVERR) r_err <= 1'b1;
      if (w_timeout) begin
        r_err  <= 1'b1;
        r_done <= 1'b0;
      end
    end
  end

  assign cfg_done = r_done;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign err      = r_err;

endmodule
